// File: rtl/vote_result_reader.sv
// Host-side reader for the vote counter: pulses Close/Result, captures total and 15 tallies, then picks the winner.
// Optional checksum compare against the total is enabled by defining VOTE_READER_CHECKSUM_EN.
module vote_result_reader #(
  parameter int TOT_WAIT = 1,
  parameter int RES_HIGH = 3,
  parameter int RES_LOW  = 2
) (
  input  logic        clk,
  input  logic        Power,
  input  logic        start,
  input  logic        abort,
  input  logic [11:0] vote_in,
  output logic        Close,
  output logic        Result,
  output logic        busy,
  output logic        done,
  output logic [11:0] total,
  output logic [3:0]  winner,
  output logic [11:0] winner_votes,
  output logic        tie,
  output logic        mismatch,
  input  logic [3:0]  rd_addr,
  output logic [11:0] rd_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLOSE,
    S_TWAIT,
    S_RHI,
    S_RLO,
    S_SCAN,
    S_DONE
  } state_t;

  localparam logic [7:0] TW_LAST = 8'(TOT_WAIT - 1);
  localparam logic [7:0] RH_LAST = 8'(RES_HIGH - 1);
  localparam logic [7:0] RL_LAST = 8'(RES_LOW - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic [3:0]  idx;
  logic [11:0] max_votes;
  logic [11:0] tbl [16];

  logic        start_ok;
  logic [11:0] scan_val;
  logic        scan_gt;
  logic [11:0] scan_max;

  assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));
  assign scan_val = tbl[idx];
  assign scan_gt  = scan_val > max_votes;
  assign scan_max = scan_gt ? scan_val : max_votes;

  // Entry 0 is never written by a readout, but the guard keeps index 0 reading zero regardless.
  assign rd_data = (rd_addr == 4'd0) ? 12'd0 : tbl[rd_addr];

  always_ff @(posedge clk or posedge Power) begin
    if (Power) begin
      state        <= S_IDLE;
      cnt          <= '0;
      idx          <= 4'd1;
      max_votes    <= '0;
      Close        <= 1'b0;
      Result       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      total        <= '0;
      winner       <= '0;
      winner_votes <= '0;
      tie          <= 1'b0;
      for (int i = 0; i < 16; i++) tbl[i] <= '0;
    end else if (abort) begin
      state  <= S_IDLE;
      cnt    <= '0;
      Close  <= 1'b0;
      Result <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state        <= S_CLOSE;
            cnt          <= '0;
            idx          <= 4'd1;
            max_votes    <= '0;
            Close        <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
            total        <= '0;
            winner       <= '0;
            winner_votes <= '0;
            tie          <= 1'b0;
            for (int i = 0; i < 16; i++) tbl[i] <= '0;
          end
        end

        S_CLOSE: begin
          Close <= 1'b0;
          cnt   <= '0;
          state <= S_TWAIT;
        end

        S_TWAIT: begin
          if (cnt == TW_LAST) begin
            total  <= vote_in;
            Result <= 1'b1;
            idx    <= 4'd1;
            cnt    <= '0;
            state  <= S_RHI;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        // The tally is taken on the final high cycle, as Result falls.
        S_RHI: begin
          if (cnt == RH_LAST) begin
            tbl[idx] <= vote_in;
            Result   <= 1'b0;
            cnt      <= '0;
            state    <= S_RLO;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        S_RLO: begin
          if (cnt == RL_LAST) begin
            cnt <= '0;
            if (idx == 4'd15) begin
              idx   <= 4'd1;
              state <= S_SCAN;
            end else begin
              idx    <= idx + 4'd1;
              Result <= 1'b1;
              state  <= S_RHI;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        // Only a strictly larger tally replaces the winner, so the lowest index wins among equals.
        S_SCAN: begin
          if (scan_gt) begin
            max_votes <= scan_val;
            winner    <= idx;
            tie       <= 1'b0;
          end else if ((scan_val == max_votes) && (max_votes != 12'd0)) begin
            tie <= 1'b1;
          end
          if (idx == 4'd15) begin
            winner_votes <= scan_max;
            busy         <= 1'b0;
            done         <= 1'b1;
            state        <= S_DONE;
          end else begin
            idx <= idx + 4'd1;
          end
        end

        default: begin
          state  <= S_IDLE;
          Close  <= 1'b0;
          Result <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b0;
        end
      endcase
    end
  end

`ifdef VOTE_READER_CHECKSUM_EN
  logic [15:0] sum;
  logic [15:0] sum_next;

  assign sum_next = sum + {4'd0, scan_val};

  // The last SCAN edge folds in entry 15 before comparing, so the compare lands on the DONE entry edge.
  always_ff @(posedge clk or posedge Power) begin
    if (Power) begin
      sum      <= '0;
      mismatch <= 1'b0;
    end else if (!abort) begin
      if (start_ok) begin
        sum      <= '0;
        mismatch <= 1'b0;
      end else if (state == S_SCAN) begin
        sum <= sum_next;
        if (idx == 4'd15) mismatch <= (sum_next != {4'd0, total});
      end
    end
  end
`else
  assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_vote_result_reader.sv
// Self-checking bench for vote_result_reader: a simple counter model drives vote_in and a reference model predicts results.
module tb_vote_result_reader;

  logic        clk = 1'b0;
  logic        Power;
  logic        start;
  logic        abort;
  logic [11:0] vote_in;
  logic        Close;
  logic        Result;
  logic        busy;
  logic        done;
  logic [11:0] total;
  logic [3:0]  winner;
  logic [11:0] winner_votes;
  logic        tie;
  logic        mismatch;
  logic [3:0]  rd_addr;
  logic [11:0] rd_data;

  int checks = 0;
  int failures = 0;

  // Counter model: Close rewinds it to the total, each Result pulse advances to the next candidate.
  logic [11:0] m_tally [16];
  int          m_total = 0;
  int          rc = 0;
  int          close_pulses = 0;
  bit          overlap_seen = 1'b0;

  logic [3:0]  exp_winner;
  logic [11:0] exp_votes;
  logic        exp_tie;
  logic        exp_mismatch;

  vote_result_reader dut (
    .clk          (clk),
    .Power        (Power),
    .start        (start),
    .abort        (abort),
    .vote_in      (vote_in),
    .Close        (Close),
    .Result       (Result),
    .busy         (busy),
    .done         (done),
    .total        (total),
    .winner       (winner),
    .winner_votes (winner_votes),
    .tie          (tie),
    .mismatch     (mismatch),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge Close or posedge Result) begin
    if (Close) rc = 0;
    else rc = rc + 1;
  end

  always @(posedge Close) close_pulses = close_pulses + 1;

  always @(negedge clk) if (Close && Result) overlap_seen = 1'b1;

  always_comb begin
    vote_in = 12'd0;
    if (rc == 0) vote_in = m_total[11:0];
    else if (rc <= 15) vote_in = m_tally[rc];
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < 16; i++) m_tally[i] = 12'd0;
    m_total = 0;
  endtask

  // Reference: largest tally, lowest index on equals; tie if that nonzero maximum occurs more than once.
  task automatic computeExpected();
    int best;
    int hits;
    int sum;
    best = 0;
    hits = 0;
    sum = 0;
    exp_winner = 4'd0;
    for (int i = 1; i <= 15; i++) begin
      sum += int'(m_tally[i]);
      if (int'(m_tally[i]) > best) begin
        best = int'(m_tally[i]);
        exp_winner = 4'(i);
      end
    end
    for (int i = 1; i <= 15; i++) if (int'(m_tally[i]) == best) hits++;
    exp_votes = 12'(best);
    exp_tie = (best != 0) && (hits > 1);
`ifdef VOTE_READER_CHECKSUM_EN
    exp_mismatch = (sum != m_total);
`else
    exp_mismatch = 1'b0;
`endif
  endtask

  // Start is sampled on edge E0; cycles counts edges after E0 until done is seen.
  task automatic applyStimulus(input bit poke, output int cycles, output logic busy_e0);
    cycles = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    busy_e0 = busy;
    while (!done && cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
      start = poke && (cycles == 10 || cycles == 60);
    end
    start = 1'b0;
  endtask

  task automatic waitCandidate(input int k, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (rc == k && Result) ok = 1'b1;
    end
  endtask

  task automatic runCase(input string name, input bit poke, input bit check_table);
    int          cyc;
    logic        b0;
    int          pulses_before;
    pulses_before = close_pulses;
    computeExpected();
    applyStimulus(poke, cyc, b0);
    checkOutput({name, "_busy_at_start"}, 16'(b0), 16'd1);
    checkOutput({name, "_done_latency"}, 16'(cyc), 16'd92);
    checkOutput({name, "_busy_after"}, 16'(busy), 16'd0);
    checkOutput({name, "_total"}, 16'(total), 16'(m_total[11:0]));
    checkOutput({name, "_winner"}, 16'(winner), 16'(exp_winner));
    checkOutput({name, "_winner_votes"}, 16'(winner_votes), 16'(exp_votes));
    checkOutput({name, "_tie"}, 16'(tie), 16'(exp_tie));
    checkOutput({name, "_mismatch"}, 16'(mismatch), 16'(exp_mismatch));
    checkOutput({name, "_close_pulses"}, 16'(close_pulses - pulses_before), 16'd1);
    checkOutput({name, "_result_pulses"}, 16'(rc), 16'd15);
    if (check_table) begin
      for (int a = 0; a < 16; a++) begin
        rd_addr = 4'(a);
        #1;
        checkOutput($sformatf("%s_rd_%0d", name, a), 16'(rd_data), (a == 0) ? 16'd0 : 16'(m_tally[a]));
      end
    end
  endtask

  initial begin
    bit ok;
    int s;
    Power = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    rd_addr = 4'd0;
    clearModel();
    $display("[TB] reset state");
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_close", 16'(Close), 16'd0);
    checkOutput("rst_result", 16'(Result), 16'd0);
    checkOutput("rst_busy", 16'(busy), 16'd0);
    checkOutput("rst_done", 16'(done), 16'd0);
    checkOutput("rst_total", 16'(total), 16'd0);
    checkOutput("rst_winner", 16'(winner), 16'd0);
    checkOutput("rst_winner_votes", 16'(winner_votes), 16'd0);
    checkOutput("rst_tie", 16'(tie), 16'd0);
    checkOutput("rst_mismatch", 16'(mismatch), 16'd0);
    rd_addr = 4'd5;
    #1;
    checkOutput("rst_rd5", 16'(rd_data), 16'd0);
    @(negedge clk);
    Power = 1'b0;

    $display("[TB] reset during candidate 7");
    for (int i = 1; i <= 15; i++) m_tally[i] = 12'(i * 3 + 1);
    m_total = 100;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitCandidate(7, ok);
    checkOutput("mid_reach_k7", 16'(ok), 16'd1);
    #2;
    Power = 1'b1;
    #1;
    rd_addr = 4'd1;
    #1;
    checkOutput("mid_rst_rd1", 16'(rd_data), 16'd0);
    checkOutput("mid_rst_close", 16'(Close), 16'd0);
    checkOutput("mid_rst_result", 16'(Result), 16'd0);
    checkOutput("mid_rst_busy", 16'(busy), 16'd0);
    checkOutput("mid_rst_total", 16'(total), 16'd0);
    @(negedge clk);
    Power = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("mid_rst_idle_close", 16'(Close), 16'd0);
    checkOutput("mid_rst_idle_busy", 16'(busy), 16'd0);

    $display("[TB] directed readouts");
    clearModel();
    m_total = 9;
    m_tally[3] = 12'd5;
    m_tally[8] = 12'd4;
    runCase("c3c8", 1'b0, 1'b1);

    clearModel();
    m_total = 12;
    m_tally[2] = 12'd6;
    m_tally[11] = 12'd6;
    runCase("tie2_11", 1'b0, 1'b0);

    clearModel();
    runCase("all_zero", 1'b0, 1'b0);

    clearModel();
    m_total = 10;
    m_tally[1] = 12'd4;
    m_tally[5] = 12'd5;
    runCase("sum_diff", 1'b0, 1'b0);

    $display("[TB] abort and ignored starts");
    clearModel();
    for (int i = 1; i <= 15; i++) m_tally[i] = 12'($urandom_range(1, 200));
    m_total = 50;
    s = close_pulses;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitCandidate(2, ok);
    checkOutput("ab_reach_k2", 16'(ok), 16'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitCandidate(4, ok);
    checkOutput("ab_reach_k4", 16'(ok), 16'd1);
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    start = 1'b0;
    checkOutput("ab_close", 16'(Close), 16'd0);
    checkOutput("ab_result", 16'(Result), 16'd0);
    checkOutput("ab_busy", 16'(busy), 16'd0);
    checkOutput("ab_done", 16'(done), 16'd0);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("ab_idle_busy", 16'(busy), 16'd0);
    checkOutput("ab_close_pulses", 16'(close_pulses - s), 16'd1);
    clearModel();
    m_total = 30;
    m_tally[4] = 12'd17;
    m_tally[9] = 12'd13;
    runCase("after_abort", 1'b1, 1'b1);

    $display("[TB] randomized readouts");
    for (int it = 0; it < 6; it++) begin
      int sum;
      sum = 0;
      for (int i = 1; i <= 15; i++) begin
        case (it % 3)
          0: m_tally[i] = 12'($urandom_range(0, 4095));
          1: m_tally[i] = 12'($urandom_range(0, 3));
          default: m_tally[i] = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(1, 300)) : 12'd0;
        endcase
        sum += int'(m_tally[i]);
      end
      m_total = ((it % 2) == 1 && sum <= 4095) ? sum : int'($urandom_range(0, 4095));
      runCase($sformatf("rand%0d", it), (it % 2) == 0, 1'b1);
    end

    checkOutput("no_close_result_overlap", 16'(overlap_seen), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vote_result_reader.md
# vote_result_reader

- Host-side collector for the vote counter's result port.
- On a start request it:
  - issues the Close/Result pulse sequence;
  - captures the total and all 15 candidate tallies from the counter's 12-bit output bus into an internal table;
  - scans the table for the winner.
- The captured table can be read back on a random-access port by the display/report logic.

## Interface

Parameters:
- TOT_WAIT, 1: cycles between Close deassertion and total capture.
- RES_HIGH, 3: cycles Result is held high per candidate; tally captured on the last one.
- RES_LOW, 2: cycles Result is held low between candidates.

Ports:
- clk, input, 1: single clock; all state changes on its rising edge.
- Power, input, 1: reset, asynchronous, active-high.
- start, input, 1: begin a readout; sampled in IDLE and DONE only.
- abort, input, 1: synchronous; returns to IDLE from any state, drops Close/Result.
- vote_in, input, 12: counter output bus.
- Close, output, 1: registered; to counter Close.
- Result, output, 1: registered; to counter Result.
- busy, output, 1: high in every state except IDLE and DONE.
- done, output, 1: level; high in DONE.
- total, output, 12: captured total vote count.
- winner, output, 4: winning candidate 1..15; 0 = no votes.
- winner_votes, output, 12: winner's tally.
- tie, output, 1: another candidate equals the winning tally (nonzero).
- mismatch, output, 1: sum of tallies differs from total (see Configuration).
- rd_addr, input, 4: table read index 1..15; index 0 reads 0.
- rd_data, output, 12: combinational table[rd_addr].

## Operation

States: IDLE, CLOSE, TWAIT, RHI, RLO, SCAN, DONE.

Transitions:
- IDLE, start=1 -> CLOSE. This clears the table and total, and zeroes all result outputs.
- CLOSE, 1 cycle, Close=1 -> TWAIT.
- TWAIT, TOT_WAIT cycles. On the last edge: total <= vote_in, then -> RHI with candidate index k=1.
- RHI, RESULT=1 for RES_HIGH cycles. On the last edge: table[k] <= vote_in, then -> RLO.
- RLO, Result=0 for RES_LOW cycles:
  - k<15: k++, -> RHI;
  - k=15: -> SCAN with j=1.
- SCAN, 15 cycles, one entry per cycle:
  - table[j] > max: max <= table[j], winner <= j, tie <= 0;
  - table[j] == max and max != 0: tie <= 1.
  - The first strictly-greater entry wins, so the lowest index wins among equals.
- SCAN also accumulates a 16-bit sum of the tallies; 15×4095 fits, so there is no overflow.
- SCAN end -> DONE; winner_votes <= max.
- DONE holds all results.
  - start=1 -> CLOSE, which clears the previous results.
- abort in any state:
  - -> IDLE next edge; Close=Result=0.
  - Table and results are left as-is; done=0.
- abort has priority over start; start while busy is ignored.

## Timing

- Reset: Close=0, Result=0, busy=0, done=0, total=0, winner=0, winner_votes=0, tie=0, mismatch=0, all table entries 0, state IDLE.
- start sampled at edge E0:
  - Close is high E0..E1.
  - total is captured at E1+TOT_WAIT.
  - Candidate k: Result rises at E1+TOT_WAIT+(k-1)(RES_HIGH+RES_LOW); tally captured RES_HIGH edges later.
- done rises at E0 + 1 + TOT_WAIT + 15(RES_HIGH+RES_LOW) + 15.
  - Defaults: E0+92.
- busy rises at E0 and falls with done.
- Close and Result never overlap; Result is low on entry to SCAN and stays low.
- rd_data is valid the same cycle as rd_addr. During a readout it reflects the partially filled table.

## Configuration

- VOTE_READER_CHECKSUM_EN defined:
  - SCAN keeps the 16-bit running sum.
  - At the DONE entry edge: mismatch <= (sum != zero-extended total).
  - mismatch clears on start and on reset.
- Undefined:
  - No sum register.
  - mismatch tied 0.
  - Timing unchanged.

## Test plan

- Reset mid-RHI (k=7): outputs and table return to 0 immediately, state IDLE, Close/Result low.
- Counter model holding total 9, tallies c3=5, c8=4, rest 0, defaults: done at E0+92; total=9, winner=3, winner_votes=5, tie=0, mismatch=0; rd_addr=8 -> rd_data=4.
- Tallies c2=6, c11=6, total 12: winner=2, winner_votes=6, tie=1.
- All zero, total 0: winner=0, winner_votes=0, tie=0.
- Total 10, tallies c1=4, c5=5:
  - with VOTE_READER_CHECKSUM_EN, mismatch=1;
  - without it, mismatch=0.
- abort at k=4, then start again, plus start pulses while busy:
  - Close pulses exactly once per accepted start;
  - ignored starts cause no extra pulses;
  - the second readout completes 92 cycles after its start with correct results.
